// File: rtl/phase_seq_rf.sv
// Four-phase sequencer, instruction register, 16x16 register file and PC for the 16-bit core.
// Feeds ph/ir/pc/sr1/sr2 to the ALU and retires its registered result q on the PH3 edge.
module phase_seq_rf #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  input  logic [15:0] q,
  output logic [3:0]  ph,
  output logic [15:0] ir,
  output logic [15:0] pc,
  output logic [15:0] sr1,
  output logic [15:0] sr2,
  output logic        halted
);

  localparam logic [3:0] PH1 = 4'b0001;
  localparam logic [3:0] PH2 = 4'b0010;
  localparam logic [3:0] PH3 = 4'b0100;
  localparam logic [3:0] PH4 = 4'b1000;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LI   = 4'h2;
  localparam logic [3:0] OP_B    = 4'h3;
  localparam logic [3:0] OP_BNZ  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [3:0]  ph_r;
  logic [15:0] ir_r;
  logic [15:0] pc_r;
  logic        halted_r;
  logic [15:0] regs_r [16];

  logic [3:0]  op_s;
  logic [3:0]  rd_s;
  logic [3:0]  ra1_s;
  logic [15:0] sr1_s;
  logic [15:0] pc_next_s;
  logic        wr_en_s;
  logic        halt_s;

  assign op_s  = ir_r[15:12];
  assign rd_s  = ir_r[11:8];
  assign sr1_s = regs_r[ra1_s];

  // Decode read-port-1 address; BNZ tests the register in the rd field.
  always_comb begin
    ra1_s = ir_r[7:4];
    if (op_s == OP_BNZ) begin
      ra1_s = ir_r[11:8];
    end else begin
      ra1_s = ir_r[7:4];
    end
  end

  // Retire decision for the PH3 edge: next PC, register write enable and halt request.
  always_comb begin
    pc_next_s = pc_r + 16'h0001;
    wr_en_s   = 1'b0;
    halt_s    = 1'b0;
    case (op_s)
      OP_ADD, OP_LI: wr_en_s = 1'b1;
      OP_B:          pc_next_s = q;
      OP_BNZ: begin
        if (sr1_s != 16'h0000) begin
          pc_next_s = q;
        end else begin
          pc_next_s = pc_r + 16'h0001;
        end
      end
      OP_HALT: begin
        pc_next_s = pc_r;
        halt_s    = 1'b1;
      end
      default: pc_next_s = pc_r + 16'h0001;
    endcase
  end

  // Phase sequencer: PH1 stalls without valid fetch data, PH4 freezes once halted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ph_r <= PH1;
    end else begin
      case (ph_r)
        PH1:     ph_r <= imem_valid ? PH2 : PH1;
        PH2:     ph_r <= PH3;
        PH3:     ph_r <= PH4;
        PH4:     ph_r <= halted_r ? PH4 : PH1;
        default: ph_r <= PH1;
      endcase
    end
  end

  // Instruction register loads only on the accepting PH1 edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ir_r <= 16'h0000;
    end else if ((ph_r == PH1) && imem_valid) begin
      ir_r <= imem_rdata;
    end
  end

  // PC and halt flag retire on the PH3 edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else if (ph_r == PH3) begin
      pc_r     <= pc_next_s;
      halted_r <= halted_r | halt_s;
    end
  end

  // Register file write-back of q; reads happen in PH1/PH2 so no bypass is needed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= 16'h0000;
      end
    end else if ((ph_r == PH3) && wr_en_s) begin
      regs_r[rd_s] <= q;
    end
  end

  assign ph        = ph_r;
  assign ir        = ir_r;
  assign pc        = pc_r;
  assign imem_addr = pc_r;
  assign halted    = halted_r;
  assign sr1       = sr1_s;
  assign sr2       = regs_r[ir_r[3:0]];

endmodule
